// File: rtl/replay_pkg.sv
// Shared definitions for the replay buffer controller: FSM encoding,
// LFSR feedback taps and the packed experience layout.
package replay_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SAMPLE = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Feedback taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Experience packing, MSB first:
  // {current_state_0, current_state_1, action, reward, next_state_0, next_state_1, done}
  function automatic int unsigned exp_width(input int unsigned dw, input int unsigned aw);
    return 5 * dw + aw + 1;
  endfunction

  function automatic int unsigned off_done();
    return 0;
  endfunction

  function automatic int unsigned off_next_state_1();
    return 1;
  endfunction

  function automatic int unsigned off_next_state_0(input int unsigned dw);
    return 1 + dw;
  endfunction

  function automatic int unsigned off_reward(input int unsigned dw);
    return 1 + 2 * dw;
  endfunction

  function automatic int unsigned off_action(input int unsigned dw);
    return 1 + 3 * dw;
  endfunction

  function automatic int unsigned off_current_state_1(input int unsigned dw, input int unsigned aw);
    return 1 + 3 * dw + aw;
  endfunction

  function automatic int unsigned off_current_state_0(input int unsigned dw, input int unsigned aw);
    return 1 + 4 * dw + aw;
  endfunction

  // One Fibonacci shift: new bit enters at the LSB.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/replay_buffer_ctrl_lfsr16.sv
// 16-bit Fibonacci LFSR used as the random sample address source.
module lfsr16
  import replay_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  output logic [15:0] o_value
);

  // Advance one step per enabled cycle; reload the seed on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_value <= SEED;
    end else if (i_en) begin
      o_value <= lfsr_next(o_value);
    end
  end

endmodule

// File: rtl/replay_buffer_ctrl.sv
// Replay buffer controller: circular write pointer into an external replay
// RAM plus a minibatch sampler issuing LFSR-chosen reads with rejection.
module replay_buffer_ctrl
  import replay_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MEMORY_WIDTH = 10000,
  parameter int unsigned ACTION_WIDTH = 2,
  parameter int unsigned BATCH_SIZE   = 32,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  localparam int unsigned ADDR_W      = $clog2(MEMORY_WIDTH),
  localparam int unsigned EXP_W       = exp_width(DATA_WIDTH, ACTION_WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_store_valid,
  input  logic [EXP_W-1:0]  i_exp,
  input  logic              i_sample_req,
  input  logic              i_ram_valid,
  output logic              o_ram_valid,
  output logic              o_ram_rw_select,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [EXP_W-1:0]  o_ram_exp,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_sample_busy,
  output logic              o_sample_done
);

  localparam int unsigned CNT_W = $clog2(BATCH_SIZE + 1);
  localparam logic [ADDR_W:0]   COUNT_MAX = (ADDR_W + 1)'(MEMORY_WIDTH);
  localparam logic [ADDR_W:0]   COUNT_MIN = (ADDR_W + 1)'(BATCH_SIZE);
  localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(MEMORY_WIDTH - 1);
  localparam logic [CNT_W-1:0]  BATCH     = CNT_W'(BATCH_SIZE);

  state_t            state;
  state_t            state_next;
  logic              start;
  logic [ADDR_W-1:0] wr_ptr;
  logic [CNT_W-1:0]  issued;
  logic [CNT_W-1:0]  returned;
  logic [15:0]       lfsr_value;
  logic [ADDR_W-1:0] cand;
  logic              cand_ok;
  logic              do_write;
  logic              do_read;
  logic              lfsr_en;
  logic              ret_ok;

  assign cand     = ADDR_W'(lfsr_value);
  assign cand_ok  = {1'b0, cand} < o_count;
  assign do_write = i_store_valid;
  // A write always wins; the pending read simply retries on the next free cycle.
  assign lfsr_en  = (state == S_SAMPLE) && !i_store_valid;
  assign do_read  = lfsr_en && (issued != BATCH) && cand_ok;
  assign ret_ok   = i_ram_valid && ((state == S_SAMPLE) || (state == S_DRAIN))
                    && (returned != BATCH);

  assign o_full        = (o_count == COUNT_MAX);
  assign o_sample_busy = (state == S_SAMPLE) || (state == S_DRAIN);
  assign o_sample_done = (state == S_DONE);

  lfsr16 #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .i_en   (lfsr_en),
    .o_value(lfsr_value)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; start marks entry into SAMPLE.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (i_sample_req && (o_count >= COUNT_MIN)) begin
          state_next = S_SAMPLE;
          start      = 1'b1;
        end
      end
      S_SAMPLE: begin
        if (issued == BATCH) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (returned == BATCH) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Registered RAM command, write pointer, fill count and batch counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_ram_valid     <= 1'b0;
      o_ram_rw_select <= 1'b0;
      o_ram_addr      <= '0;
      o_ram_exp       <= '0;
      o_count         <= '0;
      wr_ptr          <= '0;
      issued          <= '0;
      returned        <= '0;
    end else begin
      o_ram_valid     <= do_write || do_read;
      o_ram_rw_select <= do_read;
      if (do_write) begin
        o_ram_addr <= wr_ptr;
        o_ram_exp  <= i_exp;
        wr_ptr     <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + ADDR_W'(1);
        if (o_count != COUNT_MAX) begin
          o_count <= o_count + (ADDR_W + 1)'(1);
        end
      end else if (do_read) begin
        o_ram_addr <= cand;
      end
      if (start) begin
        issued   <= '0;
        returned <= '0;
      end else begin
        if (do_read) begin
          issued <= issued + CNT_W'(1);
        end
        if (ret_ok) begin
          returned <= returned + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_replay_buffer_ctrl.sv
// Directed bench for replay_buffer_ctrl with a one-cycle-latency RAM responder.
module tb_replay_buffer_ctrl;

  localparam int unsigned DW     = 32;
  localparam int unsigned MEM    = 10000;
  localparam int unsigned AW     = 2;
  localparam int unsigned BATCH  = 32;
  localparam int unsigned ADDR_W = 14;
  localparam int unsigned EXP_W  = 5 * DW + AW + 1;
  localparam int unsigned BOUND  = 40000;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_store_valid;
  logic [EXP_W-1:0]  i_exp;
  logic              i_sample_req;
  logic              i_ram_valid;
  logic              o_ram_valid;
  logic              o_ram_rw_select;
  logic [ADDR_W-1:0] o_ram_addr;
  logic [EXP_W-1:0]  o_ram_exp;
  logic [ADDR_W:0]   o_count;
  logic              o_full;
  logic              o_sample_busy;
  logic              o_sample_done;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [ADDR_W-1:0] rd_addr_q[$];
  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [EXP_W-1:0]  wr_exp_q[$];
  logic [ADDR_W-1:0] exp_rd_q[$];
  int unsigned       n_done;
  logic              busy_seen;
  logic              rd_prev;

  replay_buffer_ctrl #(
    .DATA_WIDTH  (DW),
    .MEMORY_WIDTH(MEM),
    .ACTION_WIDTH(AW),
    .BATCH_SIZE  (BATCH),
    .LFSR_SEED   (16'hACE1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_store_valid  (i_store_valid),
    .i_exp          (i_exp),
    .i_sample_req   (i_sample_req),
    .i_ram_valid    (i_ram_valid),
    .o_ram_valid    (o_ram_valid),
    .o_ram_rw_select(o_ram_rw_select),
    .o_ram_addr     (o_ram_addr),
    .o_ram_exp      (o_ram_exp),
    .o_count        (o_count),
    .o_full         (o_full),
    .o_sample_busy  (o_sample_busy),
    .o_sample_done  (o_sample_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [EXP_W-1:0] make_exp(input int unsigned i);
    return {32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i), 2'(i),
            32'hCAFE_0000 + 32'(i), 32'h3000_0000 + 32'(i), 32'h4000_0000 + 32'(i), i[0]};
  endfunction

  // Reference sequence: first n LFSR candidates (from the seed) below the bound.
  task automatic build_expected(input int unsigned bound, input int unsigned n);
    logic [15:0] v;
    logic        fb;
    v = 16'hACE1;
    exp_rd_q.delete();
    for (int unsigned k = 0; k < 70000 && exp_rd_q.size() < n; k++) begin
      if (32'(v[13:0]) < bound) exp_rd_q.push_back(v[13:0]);
      fb = v[15] ^ v[13] ^ v[12] ^ v[10];
      v  = {v[14:0], fb};
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) step();
  endtask

  task automatic clear_stats();
    rd_addr_q.delete();
    wr_addr_q.delete();
    wr_exp_q.delete();
    n_done    = 0;
    busy_seen = 1'b0;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    i_store_valid = 1'b0;
    i_sample_req  = 1'b0;
    i_exp         = '0;
    settle(2);
    rst = 1'b0;
    clear_stats();
  endtask

  task automatic write_n(input int unsigned n, input int unsigned base);
    for (int unsigned k = 0; k < n; k++) begin
      i_store_valid = 1'b1;
      i_exp         = make_exp(base + k);
      step();
    end
    i_store_valid = 1'b0;
  endtask

  task automatic pulse_req();
    i_sample_req = 1'b1;
    step();
    i_sample_req = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int unsigned cyc;
    cyc = 0;
    while (n_done == 0 && cyc < BOUND) begin
      step();
      cyc++;
    end
    check({tag, "_timeout"}, cyc < BOUND, 1'b1);
  endtask

  // RAM responder and output monitor, sampled mid-cycle.
  initial begin
    i_ram_valid = 1'b0;
    rd_prev     = 1'b0;
    n_done      = 0;
    busy_seen   = 1'b0;
    forever begin
      @(negedge clk);
      i_ram_valid = rd_prev;
      rd_prev     = o_ram_valid && o_ram_rw_select;
      if (o_ram_valid) begin
        if (o_ram_rw_select) begin
          rd_addr_q.push_back(o_ram_addr);
        end else begin
          wr_addr_q.push_back(o_ram_addr);
          wr_exp_q.push_back(o_ram_exp);
        end
      end
      if (o_sample_done) n_done++;
      if (o_sample_busy) busy_seen = 1'b1;
    end
  end

  initial begin
    int unsigned max_rd;
    int unsigned rd_mark;

    // Reset values.
    do_reset();
    check("rst_valid", o_ram_valid, 1'b0);
    check("rst_rw", o_ram_rw_select, 1'b0);
    check("rst_addr", o_ram_addr, '0);
    check("rst_exp", o_ram_exp, '0);
    check("rst_count", o_count, '0);
    check("rst_full", o_full, 1'b0);
    check("rst_busy", o_sample_busy, 1'b0);
    check("rst_done", o_sample_done, 1'b0);

    // Three writes land at 0, 1, 2.
    write_n(3, 0);
    settle(2);
    check("w3_num", wr_addr_q.size(), 3);
    for (int unsigned k = 0; k < 3; k++) begin
      check($sformatf("w3_addr%0d", k), wr_addr_q[k], k);
      check($sformatf("w3_exp%0d", k), wr_exp_q[k], make_exp(k));
    end
    check("w3_count", o_count, 3);
    check("w3_full", o_full, 1'b0);

    // Request below the batch size is dropped.
    do_reset();
    write_n(20, 0);
    settle(2);
    busy_seen = 1'b0;
    pulse_req();
    settle(20);
    check("low_busy", busy_seen, 1'b0);
    check("low_done", n_done, 0);
    check("low_reads", rd_addr_q.size(), 0);
    check("low_count", o_count, 20);

    // Exactly BATCH_SIZE entries is enough to start.
    write_n(12, 20);
    settle(2);
    pulse_req();
    check("eq_busy", o_sample_busy, 1'b1);

    // Full minibatch from 100 entries, exact LFSR order.
    do_reset();
    write_n(100, 0);
    settle(2);
    clear_stats();
    build_expected(100, BATCH);
    pulse_req();
    check("b100_busy", o_sample_busy, 1'b1);
    wait_done("b100");
    settle(3);
    check("b100_reads", rd_addr_q.size(), BATCH);
    for (int unsigned k = 0; k < BATCH && k < rd_addr_q.size(); k++) begin
      check($sformatf("b100_addr%0d", k), rd_addr_q[k], exp_rd_q[k]);
    end
    check("b100_done", n_done, 1);
    check("b100_busy_end", o_sample_busy, 1'b0);
    check("b100_done_end", o_sample_done, 1'b0);
    check("b100_nowrites", wr_addr_q.size(), 0);

    // Five back-to-back writes in the middle of SAMPLE.
    do_reset();
    write_n(100, 0);
    settle(2);
    clear_stats();
    pulse_req();
    for (int unsigned k = 0; k < BOUND && rd_addr_q.size() < 5; k++) step();
    check("mid_started", rd_addr_q.size() >= 5, 1'b1);
    write_n(5, 500);
    settle(2);
    rd_mark = rd_addr_q.size();
    check("mid_writes", wr_addr_q.size(), 5);
    for (int unsigned k = 0; k < 5 && k < wr_addr_q.size(); k++) begin
      check($sformatf("mid_waddr%0d", k), wr_addr_q[k], 100 + k);
    end
    check("mid_count", o_count, 105);
    wait_done("mid");
    settle(3);
    check("mid_resumed", rd_addr_q.size() > rd_mark, 1'b1);
    check("mid_reads", rd_addr_q.size(), BATCH);
    max_rd = 0;
    foreach (rd_addr_q[k]) if (32'(rd_addr_q[k]) > max_rd) max_rd = 32'(rd_addr_q[k]);
    check("mid_bound", max_rd < 105, 1'b1);
    check("mid_done", n_done, 1);

    // Reset while draining aborts the batch.
    do_reset();
    write_n(100, 0);
    settle(2);
    clear_stats();
    pulse_req();
    for (int unsigned k = 0; k < BOUND && rd_addr_q.size() < BATCH; k++) step();
    check("drn_reads", rd_addr_q.size(), BATCH);
    step();
    check("drn_busy", o_sample_busy, 1'b1);
    rst = 1'b1;
    step();
    check("drn_valid", o_ram_valid, 1'b0);
    check("drn_rw", o_ram_rw_select, 1'b0);
    check("drn_addr", o_ram_addr, '0);
    check("drn_exp", o_ram_exp, '0);
    check("drn_count", o_count, '0);
    check("drn_full", o_full, 1'b0);
    check("drn_busy0", o_sample_busy, 1'b0);
    check("drn_done0", o_sample_done, 1'b0);
    rst = 1'b0;
    settle(10);
    check("drn_nopulse", n_done, 0);
    check("drn_idle", o_sample_busy, 1'b0);

    // Fill past capacity: pointer wraps, count saturates.
    do_reset();
    write_n(MEM - 1, 0);
    settle(2);
    check("fill_count", o_count, MEM - 1);
    check("fill_full", o_full, 1'b0);
    write_n(3, MEM - 1);
    settle(2);
    check("wrap_num", wr_addr_q.size(), MEM + 2);
    if (wr_addr_q.size() == MEM + 2) begin
      check("wrap_last_top", wr_addr_q[MEM - 1], MEM - 1);
      check("wrap_addr0", wr_addr_q[MEM], 0);
      check("wrap_addr1", wr_addr_q[MEM + 1], 1);
      check("wrap_exp1", wr_exp_q[MEM + 1], make_exp(MEM + 1));
    end
    check("wrap_count", o_count, MEM);
    check("wrap_full", o_full, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
